// File: rtl/gate_sweep_ctrl_if.sv
// Bus between a test master (plus the gate under test) and gate_sweep_ctrl.
// With GATE_SWEEP_ABORT_EN defined the bus also carries the abort request.
//
// Handshake: start is sampled on every rising edge but only acts while the
// sequencer is idle (busy=0, done=0); a start seen while busy or during the
// done cycle is dropped, never queued. done is a one-cycle pulse marking
// pass/err_count/fail_vec valid; they then hold until the next accepted start.
interface gate_sweep_ctrl_if;
   logic       start;
   logic       gate_y;
   logic       gate_a;
   logic       gate_b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   logic [1:0] fsm_state;   // debug view of the sequencer state (0 idle, 1 run, 2 done)
`ifdef GATE_SWEEP_ABORT_EN
   logic       abort;

   modport master (
      output start, gate_y, abort,
      input  gate_a, gate_b, busy, done, pass, err_count, fail_vec, fsm_state
   );
   modport slave (
      input  start, gate_y, abort,
      output gate_a, gate_b, busy, done, pass, err_count, fail_vec, fsm_state
   );
`else
   modport master (
      output start, gate_y,
      input  gate_a, gate_b, busy, done, pass, err_count, fail_vec, fsm_state
   );
   modport slave (
      input  start, gate_y,
      output gate_a, gate_b, busy, done, pass, err_count, fail_vec, fsm_state
   );
`endif
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input gate: drives 00, 01, 10, 11 for
// HOLD_CYCLES each, samples gate_y on the closing edge of every vector and
// compares it with EXP_TABLE (bit i = expected output for {gate_a,gate_b}=i).
// Optional feature: define GATE_SWEEP_ABORT_EN to add bus.abort, which
// cancels a running sweep and clears the results.
module gate_sweep_ctrl #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [3:0]  EXP_TABLE   = 4'b0001
) (
   input  logic             clk,
   input  logic             rst_n,
   gate_sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] vec;
   logic [7:0] hold;
   logic       abort_hit;
   logic       cmp_edge;
   logic       mismatch;
   logic [3:0] fail_upd;
   logic [2:0] err_upd;

`ifdef GATE_SWEEP_ABORT_EN
   assign abort_hit = (state == RUN) && bus.abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Compare edge closes a vector's hold window; an abort on the same edge wins.
   assign cmp_edge = (state == RUN) && (hold == HOLD_LAST) && !abort_hit;
   assign mismatch = (bus.gate_y != EXP_TABLE[vec]);
   assign fail_upd = bus.fail_vec | (mismatch ? (4'b0001 << vec) : 4'b0000);
   assign err_upd  = (mismatch && (bus.err_count != 3'd4)) ? bus.err_count + 3'd1
                                                           : bus.err_count;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode: IDLE -> RUN on start, RUN -> DONE after vector 3, DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            if (abort_hit)                     state_nxt = IDLE;
            else if (cmp_edge && (vec == 2'd3)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Unregistered outputs: the done pulse and the debug state view.
   always_comb begin
      bus.done      = (state == DONE);
      bus.fsm_state = state;
   end

   // Sweep datapath: vector/hold counters, registered gate drive and results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec           <= 2'd0;
         hold          <= 8'd0;
         bus.gate_a    <= 1'b0;
         bus.gate_b    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.pass      <= 1'b0;
         bus.err_count <= 3'd0;
         bus.fail_vec  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  vec           <= 2'd0;
                  hold          <= 8'd0;
                  bus.gate_a    <= 1'b0;
                  bus.gate_b    <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.pass      <= 1'b0;
                  bus.err_count <= 3'd0;
                  bus.fail_vec  <= 4'd0;
               end
            end
            RUN: begin
               if (abort_hit) begin
                  vec           <= 2'd0;
                  hold          <= 8'd0;
                  bus.gate_a    <= 1'b0;
                  bus.gate_b    <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.pass      <= 1'b0;
                  bus.err_count <= 3'd0;
                  bus.fail_vec  <= 4'd0;
               end else if (cmp_edge) begin
                  hold          <= 8'd0;
                  bus.fail_vec  <= fail_upd;
                  bus.err_count <= err_upd;
                  if (vec == 2'd3) begin
                     // Last vector: pass must include this vector's own result.
                     bus.busy   <= 1'b0;
                     bus.gate_a <= 1'b0;
                     bus.gate_b <= 1'b0;
                     bus.pass   <= (fail_upd == 4'd0);
                  end else begin
                     vec                      <= vec + 2'd1;
                     {bus.gate_a, bus.gate_b} <= vec + 2'd1;
                  end
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (HOLD_CYCLES=2 and 1, NOR table),
// each wired to a behavioural gate whose actual truth table the driver picks.
module tb_gate_sweep_ctrl;

   localparam int         H0      = 2;
   localparam int         H1      = 1;
   localparam logic [3:0] EXP_NOR = 4'b0001;
   localparam int         W       = 24;   // {sweep tag[15:0], pass, err[2:0], fail[3:0]}

   // ---------------- clock / reset block ----------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stimulus state (driver owned) ----------------
   logic       start_v[2];
   logic [3:0] tt_v[2];          // actual truth table of each gate under test
   int         tag_go[2];        // sweeps started
   int         tag_kill[2];      // == tag_go when results were wiped by reset/abort
   int         c0[2];            // cycle count right after the accepting edge
   logic       mon_en;
`ifdef GATE_SWEEP_ABORT_EN
   logic       abort_0;
`endif

   // ---------------- checking state (monitor owned) ----------------
   int         tag_done[2];
   logic [7:0] last_done[2];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   // ---------------- DUTs ----------------
   gate_sweep_ctrl_if bus0 ();
   gate_sweep_ctrl_if bus1 ();

   assign bus0.start  = start_v[0];
   assign bus1.start  = start_v[1];
   assign bus0.gate_y = tt_v[0][{bus0.gate_a, bus0.gate_b}];
   assign bus1.gate_y = tt_v[1][{bus1.gate_a, bus1.gate_b}];
`ifdef GATE_SWEEP_ABORT_EN
   assign bus0.abort  = abort_0;
   assign bus1.abort  = 1'b0;
`endif

   gate_sweep_ctrl #(.HOLD_CYCLES(H0), .EXP_TABLE(EXP_NOR)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   gate_sweep_ctrl #(.HOLD_CYCLES(H1), .EXP_TABLE(EXP_NOR)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // ---------------- reference model ----------------
   function automatic int hold_of(input int i);
      return (i == 0) ? H0 : H1;
   endfunction

   // Results of a full sweep: a vector fails where actual and expected tables differ.
   function automatic logic [7:0] expect_res(input logic [3:0] tt, input logic [3:0] exp_tt);
      logic [3:0] bad;
      bad = tt ^ exp_tt;
      return {(bad == 4'd0), 3'($countones(bad)), bad};
   endfunction

   function automatic logic is_active(input int i);
      return (tag_go[i] != tag_done[i]) && (tag_go[i] != tag_kill[i]);
   endfunction

   // {state[1:0], busy, gate_a, gate_b, done, pass, err[2:0], fail[3:0]}
   function automatic logic [13:0] obs(input int i);
      if (i == 0)
         return {bus0.fsm_state, bus0.busy, bus0.gate_a, bus0.gate_b, bus0.done,
                 bus0.pass, bus0.err_count, bus0.fail_vec};
      return {bus1.fsm_state, bus1.busy, bus1.gate_a, bus1.gate_b, bus1.done,
              bus1.pass, bus1.err_count, bus1.fail_vec};
   endfunction

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [13:0]  o;
      logic [W-1:0] e;
      logic [7:0]   held;
      int           off;
      int           h;
      logic         found;
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            o   = obs(i);
            h   = hold_of(i);
            off = cyc - c0[i];
            if (is_active(i)) begin
               if (off >= 0 && off < 4 * h) begin
                  // {busy, gate_a, gate_b, done}: vector k held for h cycles
                  chk("run_vec", i, 32'(o[11:8]), 32'({1'b1, 2'(off / h), 1'b0}));
               end else if (off == 4 * h) begin
                  found = 1'b0;
                  e     = '0;
                  while (!found && ((i == 0) ? exp_q0.size() : exp_q1.size()) > 0) begin
                     e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     if (e[23:8] == 16'(tag_go[i])) found = 1'b1;
                  end
                  if (!found) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL sb_empty dut%0d cycle %0d: got done with no expected entry, required one", i, cyc);
                  end else begin
                     chk("done_res", i, 32'(o), 32'({2'd2, 3'b000, 1'b1, e[7:0]}));
                  end
                  last_done[i] = found ? e[7:0] : 8'd0;
                  tag_done[i]  = tag_go[i];
               end
            end else begin
               held = (tag_kill[i] == tag_go[i]) ? 8'd0 : last_done[i];
               chk("idle", i, 32'(o), 32'({6'd0, held}));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (is_active(i) && n < 200) begin
         step();
         n++;
      end
      if (is_active(i)) begin
         $display("FAIL wait_idle dut%0d: sweep running after %0d cycles, required done", i, n);
         $fatal(1, "sweep never completed");
      end
   endtask

   task automatic do_sweep(input int i, input logic [3:0] tt);
      logic [7:0] r;
      wait_idle(i);
      tt_v[i]    = tt;
      start_v[i] = 1'b1;
      step();
      start_v[i] = 1'b0;
      tag_go[i]  = tag_go[i] + 1;
      c0[i]      = cyc;
      r          = expect_res(tt, EXP_NOR);
      if (i == 0) exp_q0.push_back({16'(tag_go[i]), r});
      else        exp_q1.push_back({16'(tag_go[i]), r});
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int sel;
      rst_n      = 1'b0;
      mon_en     = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_v[i]   = 1'b0;
         tt_v[i]      = EXP_NOR;
         tag_go[i]    = 0;
         tag_kill[i]  = 0;
         tag_done[i]  = 0;
         c0[i]        = 0;
         last_done[i] = 8'd0;
      end
`ifdef GATE_SWEEP_ABORT_EN
      abort_0 = 1'b0;
`endif
      repeat (3) step();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      // Directed: good NOR, stuck-at-0, stuck-at-1, good rerun, OR with HOLD_CYCLES=1.
      do_sweep(0, 4'b0001);
      do_sweep(0, 4'b0000);
      do_sweep(0, 4'b1111);
      do_sweep(0, 4'b0001);
      do_sweep(1, 4'b1110);
      do_sweep(1, 4'b0001);

      // Stray starts at cycle 3 (RUN) and in the DONE cycle are dropped.
      do_sweep(0, 4'b0001);
      wait_cyc(c0[0] + 2);
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      wait_cyc(c0[0] + 4 * H0);
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      repeat (4) step();

      // Synchronous reset on cycle 4 of a sweep: everything back to zero/IDLE.
      wait_idle(1);
      do_sweep(0, 4'b0000);
      wait_cyc(c0[0] + 3);
      rst_n = 1'b0;
      step();
      rst_n       = 1'b1;
      tag_kill[0] = tag_go[0];
      tag_kill[1] = tag_go[1];
      repeat (3) step();

`ifdef GATE_SWEEP_ABORT_EN
      // Abort on cycle 3 after a recorded mismatch: no done, results cleared.
      do_sweep(0, 4'b0000);
      wait_cyc(c0[0] + 2);
      abort_0 = 1'b1;
      step();
      abort_0     = 1'b0;
      tag_kill[0] = tag_go[0];
      repeat (3) step();
      // Abort while idle has no effect.
      abort_0 = 1'b1;
      step();
      abort_0 = 1'b0;
      repeat (2) step();
`endif

      // Random gates on both instances, overlapping sweeps, random gaps.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 1);
         do_sweep(sel, 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 3)) step();
      end
      wait_idle(0);
      wait_idle(1);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
